// File: rtl/fft_output_serializer.sv
// Pair-to-sample serializer: buffers two-sample beats in a small FIFO and
// re-emits them one sample per beat with frame index, last flag and sticky overflow.
module fft_output_serializer #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N),
  parameter int DEPTH         = 4,
  parameter int SLACK         = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     i_pair_valid,
  input  logic [word_size*2-1:0]   i_sample1,
  input  logic [word_size*2-1:0]   i_sample2,
  output logic                     o_pair_ready,
  output logic                     o_valid,
  output logic [word_size*2-1:0]   o_sample,
  input  logic                     i_ready,
  output logic [address_width-1:0] o_index,
  output logic                     o_last,
  output logic                     o_overflow
);

  localparam int SW = word_size * 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] RESERVE = CW'(SLACK);
  localparam logic [address_width-1:0] LAST_IDX = address_width'(N - 1);

  typedef enum logic {SAMPLE1 = 1'b0, SAMPLE2 = 1'b1} phase_t;

  logic [SW-1:0]            mem_lo [DEPTH];
  logic [SW-1:0]            mem_hi [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  phase_t                   phase;
  logic [address_width-1:0] index;
  logic                     overflow;

  logic full;
  logic push;
  logic fire;
  logic pop;

  assign full  = (count == FULL);
  assign push  = en & i_pair_valid & ~full;
  assign fire  = o_valid & i_ready;
  assign pop   = fire & (phase == SAMPLE2);

  assign o_valid      = en & (count != '0);
  assign o_pair_ready = en & ~reset & ~flush & ((FULL - count) > RESERVE);
  assign o_sample     = (phase == SAMPLE2) ? mem_hi[rd_ptr] : mem_lo[rd_ptr];
  assign o_index      = index;
  assign o_last       = o_valid & (index == LAST_IDX);
  assign o_overflow   = overflow;

  // Storage needs no reset: a slot is only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_lo[wr_ptr] <= i_sample1;
      mem_hi[wr_ptr] <= i_sample2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      phase    <= SAMPLE1;
      index    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      // A pair arriving at a full FIFO is dropped, even if a pop frees space this cycle.
      if (i_pair_valid && full) overflow <= 1'b1;
      if (fire) begin
        phase <= (phase == SAMPLE1) ? SAMPLE2 : SAMPLE1;
        index <= (index == LAST_IDX) ? '0 : index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Testbench for fft_output_serializer: directed table, multi-cycle corner
// sequences and randomized traffic against a sample-queue reference model.
module tb_fft_output_serializer;

  localparam int N     = 32;
  localparam int W     = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam int SW    = 2 * W;

  logic          clk = 1'b0;
  logic          reset, en, flush, pairValid, sampleReady;
  logic [SW-1:0] sample1, sample2;
  logic          pairReady, outValid, outLast, outOverflow;
  logic [SW-1:0] outSample;
  logic [AW-1:0] outIndex;

  int  checks = 0;
  int  errors = 0;
  bit  checking = 1'b0;

  // Reference model: FIFO content as a flat queue of samples still to emit.
  logic [SW-1:0] q[$];
  int            mIndex = 0;
  bit            mOverflow = 1'b0;

  always #5 clk = ~clk;

  fft_output_serializer #(
    .N(N), .word_size(W), .address_width(AW), .DEPTH(DEPTH), .SLACK(SLACK)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .i_pair_valid(pairValid), .i_sample1(sample1), .i_sample2(sample2),
    .o_pair_ready(pairReady), .o_valid(outValid), .o_sample(outSample),
    .i_ready(sampleReady), .o_index(outIndex), .o_last(outLast),
    .o_overflow(outOverflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pairsHeld();
    return (q.size() + 1) / 2;
  endfunction

  task automatic applyStimulus(input bit r, input bit fl, input bit e, input bit pv,
                               input bit rdy, input logic [SW-1:0] s1,
                               input logic [SW-1:0] s2);
    reset = r; flush = fl; en = e; pairValid = pv; sampleReady = rdy;
    sample1 = s1; sample2 = s2;
  endtask

  task automatic checkOutput();
    bit expValid;
    if (!checking) return;
    expValid = en && (q.size() != 0);
    chk("valid", outValid, expValid);
    chk("index", outIndex, mIndex);
    chk("last", outLast, expValid && (mIndex == N - 1));
    chk("pair_ready", pairReady, en && !reset && !flush && (DEPTH - pairsHeld() > SLACK));
    chk("overflow", outOverflow, mOverflow);
    if (expValid) chk("sample", outSample, q[0]);
  endtask

  task automatic modelStep();
    int  pairs = pairsHeld();
    bit  v = q.size() != 0;
    if (reset || flush) begin
      q.delete();
      mIndex = 0;
      mOverflow = 1'b0;
    end else if (en) begin
      if (v && sampleReady) begin
        void'(q.pop_front());
        mIndex = (mIndex + 1) % N;
      end
      if (pairValid) begin
        if (pairs < DEPTH) begin
          q.push_back(sample1);
          q.push_back(sample2);
        end else begin
          mOverflow = 1'b1;
        end
      end
    end
  endtask

  task automatic sampleOutputs();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic step();
    sampleOutputs();
    advance();
  endtask

  typedef struct {
    logic rst, fl, e, pv, rdy;
    logic [SW-1:0] s1, s2;
    logic xValid;
    logic [SW-1:0] xSample;
    logic [AW-1:0] xIndex;
    logic xLast, xReady, xOvf;
  } vec_t;

  vec_t vecs[6];
  int   lastSeen;

  initial begin
    applyStimulus(0, 0, 0, 0, 0, '0, '0);
    @(posedge clk); #1;

    applyStimulus(1, 0, 1, 0, 0, '0, '0);
    step();
    checking = 1'b1;

    // Two consecutive pairs with the sink always ready.
    vecs[0] = '{0, 0, 1, 1, 1, 32'hAAAA_0001, 32'hAAAA_0002, 0, 32'h0,         5'd0, 0, 1, 0};
    vecs[1] = '{0, 0, 1, 1, 1, 32'hBBBB_0001, 32'hBBBB_0002, 1, 32'hAAAA_0001, 5'd0, 0, 1, 0};
    vecs[2] = '{0, 0, 1, 0, 1, 32'h0,         32'h0,         1, 32'hAAAA_0002, 5'd1, 0, 0, 0};
    vecs[3] = '{0, 0, 1, 0, 1, 32'h0,         32'h0,         1, 32'hBBBB_0001, 5'd2, 0, 1, 0};
    vecs[4] = '{0, 0, 1, 0, 1, 32'h0,         32'h0,         1, 32'hBBBB_0002, 5'd3, 0, 1, 0};
    vecs[5] = '{0, 0, 1, 0, 1, 32'h0,         32'h0,         0, 32'h0,         5'd4, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].e, vecs[i].pv, vecs[i].rdy,
                    vecs[i].s1, vecs[i].s2);
      sampleOutputs();
      chk("tbl_valid", outValid, vecs[i].xValid);
      chk("tbl_index", outIndex, vecs[i].xIndex);
      chk("tbl_last", outLast, vecs[i].xLast);
      chk("tbl_pair_ready", pairReady, vecs[i].xReady);
      chk("tbl_overflow", outOverflow, vecs[i].xOvf);
      if (vecs[i].xValid) chk("tbl_sample", outSample, vecs[i].xSample);
      advance();
    end

    // Fill with the sink stalled: ready drops after two pairs, fifth pair overflows.
    for (int p = 1; p <= 5; p++) begin
      applyStimulus(0, 0, 1, 1, 0, 32'hC000_0000 + 2 * p, 32'hC000_0001 + 2 * p);
      sampleOutputs();
      if (p == 3) chk("ready_drop", pairReady, 1'b0);
      if (p == 5) chk("no_ovf_yet", outOverflow, 1'b0);
      advance();
    end
    applyStimulus(0, 0, 1, 0, 1, '0, '0);
    sampleOutputs();
    chk("ovf_set", outOverflow, 1'b1);
    chk("drain_first", outSample, 32'hC000_0002);
    advance();
    for (int i = 0; i < 8; i++) step();
    applyStimulus(0, 0, 1, 0, 0, '0, '0);
    sampleOutputs();
    chk("ovf_sticky", outOverflow, 1'b1);
    chk("drained", outValid, 1'b0);
    advance();

    // Flush with three pairs buffered, then en low with a pending pair.
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 0, 1, 1, 0, 32'hD000_0000 + p, 32'hD100_0000 + p);
      step();
    end
    applyStimulus(0, 1, 1, 0, 0, '0, '0);
    sampleOutputs();
    chk("flush_ready", pairReady, 1'b0);
    advance();
    applyStimulus(0, 0, 1, 0, 0, '0, '0);
    sampleOutputs();
    chk("flush_valid", outValid, 1'b0);
    chk("flush_index", outIndex, 0);
    chk("flush_ovf", outOverflow, 1'b0);
    chk("flush_ready_after", pairReady, 1'b1);
    advance();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'hE000_0001, 32'hE000_0002);
      sampleOutputs();
      chk("en_low_valid", outValid, 1'b0);
      chk("en_low_ready", pairReady, 1'b0);
      advance();
    end
    applyStimulus(0, 0, 1, 0, 1, '0, '0);
    sampleOutputs();
    chk("en_low_no_push", outValid, 1'b0);
    advance();

    // Stall for three cycles while the second sample of a pair is presented.
    applyStimulus(0, 0, 1, 1, 0, 32'hF000_0001, 32'hF000_0002);
    step();
    applyStimulus(0, 0, 1, 0, 1, '0, '0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, '0, '0);
      sampleOutputs();
      chk("stall_sample", outSample, 32'hF000_0002);
      chk("stall_index", outIndex, 1);
      chk("stall_valid", outValid, 1'b1);
      advance();
    end
    applyStimulus(0, 0, 1, 0, 1, '0, '0);
    step();
    sampleOutputs();
    chk("stall_popped", outValid, 1'b0);
    advance();

    // Full frame plus one pair at one pair every two cycles.
    applyStimulus(1, 0, 1, 0, 1, '0, '0);
    step();
    lastSeen = 0;
    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < 2; c++) begin
        applyStimulus(0, 0, 1, c == 0, 1, 32'h1000_0000 + 2 * p, 32'h1000_0001 + 2 * p);
        sampleOutputs();
        chk("frame_ready", pairReady, 1'b1);
        if (outLast) begin
          lastSeen++;
          chk("last_index", outIndex, N - 1);
        end
        advance();
      end
    end
    chk("last_count", lastSeen, 1);

    // Randomized traffic with occasional flush/reset and enable gaps.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, $urandom, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
